multi_issue_ctrl: RTL and testbench

Parametrised N-wide in-order issue controller for the decode stage. It sits between the instruction FIFO and the ID/EX pipeline register and decides, every cycle, how many of the oldest ISSUE_W decoded instructions issue as an in-order prefix. It keeps a per-register latency scoreboard for loads and multiply results, a HI/LO scoreboard, and a divider-busy flag, so hazards spanning several cycles are resolved here rather than by single-stage compares. Slot 0 is the oldest instruction.

---
 rtl/multi_issue_ctrl.sv | 203 ++++++++++++++++++++
 tb/tb_multi_issue_ctrl.sv | 444 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_issue_ctrl.sv
// ---------------------------------------------------------------------------
// multi_issue_ctrl
//
// N-wide in-order issue controller for the decode stage. Each cycle it
// grants issue to the longest in-order prefix of the oldest ISSUE_W decoded
// instructions (slot 0 is the oldest). Multi-cycle hazards are tracked by a
// per-GPR latency scoreboard (loads and multiplies), a HI/LO scoreboard and
// a divider-busy flag; intra-group hazards are resolved by direct compares.
//
// Ports
//   clk, resetn              core clock (rising edge), async active-low reset
//   stall_in                 downstream stall: nothing issues, counters freeze
//   flush                    squash decode: nothing issues, counters still run
//   fifo_count               number of valid instruction FIFO entries
//   slot_rs/rt/waddr         per-slot register numbers (5 bits per slot)
//   slot_read_rs/rt, wen     per-slot source read / destination write enables
//   slot_is_load/mul/div/mem per-slot instruction class
//   slot_hilo_w/r, cp0_w/r   per-slot HI/LO and CP0 access
//   slot_is_branch, slot_only_one, slot_may_flush  per-slot control attributes
//   div_done                 divider completion pulse
//   slot_ena                 issue grant, contiguous prefix from bit 0
//   slot_in_delayslot        issued slot directly behind an issued branch
//   issue_cnt                popcount of slot_ena
//
// Optional feature (macro ISSUE_PERF_CNT_EN): adds 32-bit wrapping counters
//   perf_stall_cyc  (work available, nothing issued, no stall/flush) and
//   perf_full_issue (all ISSUE_W slots issued).
// ---------------------------------------------------------------------------
module multi_issue_ctrl #(
  parameter int ISSUE_W    = 2,
  parameter int FIFO_DEPTH = 16,
  parameter int LOAD_LAT   = 2,
  parameter int MUL_LAT    = 3,
  parameter int LAT_W      = 2
) (
  input  logic                             clk,
  input  logic                             resetn,
  input  logic                             stall_in,
  input  logic                             flush,
  input  logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_count,
  input  logic [5*ISSUE_W-1:0]             slot_rs,
  input  logic [5*ISSUE_W-1:0]             slot_rt,
  input  logic [5*ISSUE_W-1:0]             slot_waddr,
  input  logic [ISSUE_W-1:0]               slot_read_rs,
  input  logic [ISSUE_W-1:0]               slot_read_rt,
  input  logic [ISSUE_W-1:0]               slot_wen,
  input  logic [ISSUE_W-1:0]               slot_is_load,
  input  logic [ISSUE_W-1:0]               slot_is_mul,
  input  logic [ISSUE_W-1:0]               slot_is_div,
  input  logic [ISSUE_W-1:0]               slot_is_mem,
  input  logic [ISSUE_W-1:0]               slot_hilo_w,
  input  logic [ISSUE_W-1:0]               slot_hilo_r,
  input  logic [ISSUE_W-1:0]               slot_cp0_w,
  input  logic [ISSUE_W-1:0]               slot_cp0_r,
  input  logic [ISSUE_W-1:0]               slot_is_branch,
  input  logic [ISSUE_W-1:0]               slot_only_one,
  input  logic [ISSUE_W-1:0]               slot_may_flush,
  input  logic                             div_done,
  output logic [ISSUE_W-1:0]               slot_ena,
  output logic [ISSUE_W-1:0]               slot_in_delayslot,
  output logic [$clog2(ISSUE_W+1)-1:0]     issue_cnt
`ifdef ISSUE_PERF_CNT_EN
  ,
  output logic [31:0]                      perf_stall_cyc,
  output logic [31:0]                      perf_full_issue
`endif
);

  localparam int IC_W = $clog2(ISSUE_W+1);

  // Scoreboard state. Entry 0 of the GPR array is held at zero (r0).
  logic [LAT_W-1:0] gpr_cnt_q [32];
  logic [LAT_W-1:0] gpr_cnt_d [32];
  logic [LAT_W-1:0] hilo_cnt_q, hilo_cnt_d;
  logic             div_busy_q, div_busy_d;

  logic [ISSUE_W-1:0] hazard;
  logic [31:0]        fifo_ext;
  logic               raw, mem_seen, md_seen, hilo_w_seen, cp0_w_seen;

  assign fifo_ext = 32'(fifo_count);

  // Per-slot hazards against the multi-cycle scoreboard.
  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    hazard = '0;
    for (int i = 0; i < ISSUE_W; i++) begin
      if (slot_read_rs[i] && slot_rs[5*i +: 5] != 5'd0 &&
          gpr_cnt_q[slot_rs[5*i +: 5]] != '0)
        hazard[i] = 1'b1;
      if (slot_read_rt[i] && slot_rt[5*i +: 5] != 5'd0 &&
          gpr_cnt_q[slot_rt[5*i +: 5]] != '0)
        hazard[i] = 1'b1;
      if (slot_hilo_r[i] && hilo_cnt_q != '0)
        hazard[i] = 1'b1;
      if (div_busy_q && (slot_is_div[i] || slot_hilo_r[i] || slot_hilo_w[i]))
        hazard[i] = 1'b1;
    end
  end

  // Issue prefix. The *_seen flags accumulate over older slots; since the
  // grant is a prefix, accumulating past the first blocked slot is harmless.
  always_comb begin
    slot_ena          = '0;
    slot_in_delayslot = '0;
    raw               = 1'b0;
    slot_ena[0] = (fifo_ext != 32'd0) && !hazard[0] && !stall_in && !flush;
    mem_seen    = slot_is_mem[0];
    md_seen     = slot_is_mul[0] | slot_is_div[0];
    hilo_w_seen = slot_hilo_w[0];
    cp0_w_seen  = slot_cp0_w[0];
    for (int i = 1; i < ISSUE_W; i++) begin
      raw = 1'b0;
      for (int j = 0; j < ISSUE_W; j++) begin
        if (j < i && slot_wen[j] && slot_waddr[5*j +: 5] != 5'd0 &&
            ((slot_read_rs[i] && slot_rs[5*i +: 5] == slot_waddr[5*j +: 5]) ||
             (slot_read_rt[i] && slot_rt[5*i +: 5] == slot_waddr[5*j +: 5])))
          raw = 1'b1;
      end
      slot_ena[i] = slot_ena[i-1] && (fifo_ext > 32'(i)) && !hazard[i] && !raw
                 && !(hilo_w_seen && (slot_hilo_r[i] || slot_hilo_w[i]))
                 && !(cp0_w_seen && slot_cp0_r[i])
                 && !(mem_seen && slot_is_mem[i])
                 && !(md_seen && (slot_is_mul[i] || slot_is_div[i]))
                 && !slot_only_one[i-1] && !slot_only_one[i]
                 && !slot_may_flush[i]
                 && !slot_in_delayslot[i-1];   // stop after a delay slot
      slot_in_delayslot[i] = slot_ena[i] && slot_is_branch[i-1];
      mem_seen    = mem_seen    | slot_is_mem[i];
      md_seen     = md_seen     | slot_is_mul[i] | slot_is_div[i];
      hilo_w_seen = hilo_w_seen | slot_hilo_w[i];
      cp0_w_seen  = cp0_w_seen  | slot_cp0_w[i];
    end
  end

  always_comb begin
    issue_cnt = '0;
    for (int i = 0; i < ISSUE_W; i++)
      issue_cnt = issue_cnt + IC_W'(slot_ena[i]);
  end

  // Scoreboard next state: decrement unless stalled, then let allocation
  // override; iterating slots upward makes the youngest writer win.
  always_comb begin
    for (int r = 0; r < 32; r++) begin
      gpr_cnt_d[r] = gpr_cnt_q[r];
      if (!stall_in && gpr_cnt_q[r] != '0)
        gpr_cnt_d[r] = gpr_cnt_q[r] - LAT_W'(1);
      for (int s = 0; s < ISSUE_W; s++) begin
        if (slot_ena[s] && slot_wen[s] && slot_waddr[5*s +: 5] == 5'(r)) begin
          if (slot_is_load[s]) gpr_cnt_d[r] = LAT_W'(LOAD_LAT);
          if (slot_is_mul[s])  gpr_cnt_d[r] = LAT_W'(MUL_LAT);
        end
      end
    end
    gpr_cnt_d[0] = '0;

    hilo_cnt_d = hilo_cnt_q;
    if (!stall_in && hilo_cnt_q != '0)
      hilo_cnt_d = hilo_cnt_q - LAT_W'(1);
    for (int s = 0; s < ISSUE_W; s++)
      if (slot_ena[s] && slot_is_mul[s] && slot_hilo_w[s])
        hilo_cnt_d = LAT_W'(MUL_LAT);

    // A new div issue outranks a coincident completion pulse.
    div_busy_d = div_busy_q;
    if (div_done) div_busy_d = 1'b0;
    if ((slot_ena & slot_is_div) != '0) div_busy_d = 1'b1;
  end

  // NOTE: the scoreboard array is reset explicitly: its contents gate issue,
  // so stale counts after reset would block instructions that have no
  // producer in flight.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int r = 0; r < 32; r++) gpr_cnt_q[r] <= '0;
      hilo_cnt_q <= '0;
      div_busy_q <= 1'b0;
    end else begin
      for (int r = 0; r < 32; r++) gpr_cnt_q[r] <= gpr_cnt_d[r];
      hilo_cnt_q <= hilo_cnt_d;
      div_busy_q <= div_busy_d;
    end
  end

`ifdef ISSUE_PERF_CNT_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      perf_stall_cyc  <= '0;
      perf_full_issue <= '0;
    end else begin
      if (fifo_count != '0 && issue_cnt == '0 && !stall_in && !flush)
        perf_stall_cyc <= perf_stall_cyc + 32'd1;
      if (issue_cnt == IC_W'(ISSUE_W))
        perf_full_issue <= perf_full_issue + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_multi_issue_ctrl.sv
// ---------------------------------------------------------------------------
// Self-checking bench for multi_issue_ctrl: a 2-wide instance for the main
// scenarios and a 3-wide instance for branch / delay-slot grouping.
// Inputs change just after the falling edge; outputs are checked 1 ns later.
// ---------------------------------------------------------------------------
module tb_multi_issue_ctrl;

  logic clk, resetn, stall_in, flush, div_done;

  // 2-wide instance
  logic [4:0] fifo_count;
  logic [9:0] rs, rt, waddr;
  logic [1:0] read_rs, read_rt, wen, is_load, is_mul, is_div, is_mem;
  logic [1:0] hilo_w, hilo_r, cp0_w, cp0_r, is_branch, only_one, may_flush;
  logic [1:0] slot_ena, in_ds, issue_cnt;

  // 3-wide instance
  logic [4:0]  fifo3;
  logic [14:0] rs3, rt3, waddr3;
  logic [2:0]  read_rs3, read_rt3, wen3, branch3, zero3;
  logic [2:0]  ena3, ds3;
  logic [1:0]  cnt3;

`ifdef ISSUE_PERF_CNT_EN
  logic [31:0] perf_stall, perf_full, perf_stall3, perf_full3;
`endif

  int checks = 0;
  int errors = 0;

  multi_issue_ctrl #(.ISSUE_W(2)) dut (
    .clk(clk), .resetn(resetn), .stall_in(stall_in), .flush(flush),
    .fifo_count(fifo_count), .slot_rs(rs), .slot_rt(rt), .slot_waddr(waddr),
    .slot_read_rs(read_rs), .slot_read_rt(read_rt), .slot_wen(wen),
    .slot_is_load(is_load), .slot_is_mul(is_mul), .slot_is_div(is_div),
    .slot_is_mem(is_mem), .slot_hilo_w(hilo_w), .slot_hilo_r(hilo_r),
    .slot_cp0_w(cp0_w), .slot_cp0_r(cp0_r), .slot_is_branch(is_branch),
    .slot_only_one(only_one), .slot_may_flush(may_flush), .div_done(div_done),
    .slot_ena(slot_ena), .slot_in_delayslot(in_ds), .issue_cnt(issue_cnt)
`ifdef ISSUE_PERF_CNT_EN
    , .perf_stall_cyc(perf_stall), .perf_full_issue(perf_full)
`endif
  );

  multi_issue_ctrl #(.ISSUE_W(3)) dut3 (
    .clk(clk), .resetn(resetn), .stall_in(stall_in), .flush(flush),
    .fifo_count(fifo3), .slot_rs(rs3), .slot_rt(rt3), .slot_waddr(waddr3),
    .slot_read_rs(read_rs3), .slot_read_rt(read_rt3), .slot_wen(wen3),
    .slot_is_load(zero3), .slot_is_mul(zero3), .slot_is_div(zero3),
    .slot_is_mem(zero3), .slot_hilo_w(zero3), .slot_hilo_r(zero3),
    .slot_cp0_w(zero3), .slot_cp0_r(zero3), .slot_is_branch(branch3),
    .slot_only_one(zero3), .slot_may_flush(zero3), .div_done(div_done),
    .slot_ena(ena3), .slot_in_delayslot(ds3), .issue_cnt(cnt3)
`ifdef ISSUE_PERF_CNT_EN
    , .perf_stall_cyc(perf_stall3), .perf_full_issue(perf_full3)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_slots();
    rs = '0; rt = '0; waddr = '0; read_rs = '0; read_rt = '0; wen = '0;
    is_load = '0; is_mul = '0; is_div = '0; is_mem = '0; hilo_w = '0;
    hilo_r = '0; cp0_w = '0; cp0_r = '0; is_branch = '0; only_one = '0;
    may_flush = '0;
  endtask

  task automatic clear3();
    fifo3 = '0; rs3 = '0; rt3 = '0; waddr3 = '0; read_rs3 = '0;
    read_rt3 = '0; wen3 = '0; branch3 = '0;
  endtask

  // ALU-style op in slot s: d <- a op b
  task automatic set_alu(input int s, input logic [4:0] a, input logic [4:0] b,
                         input logic [4:0] d);
    rs[5*s +: 5] = a; rt[5*s +: 5] = b; waddr[5*s +: 5] = d;
    read_rs[s] = 1'b1; read_rt[s] = 1'b1; wen[s] = 1'b1;
  endtask

  task automatic set_alu3(input int s, input logic [4:0] a, input logic [4:0] b,
                          input logic [4:0] d);
    rs3[5*s +: 5] = a; rt3[5*s +: 5] = b; waddr3[5*s +: 5] = d;
    read_rs3[s] = 1'b1; read_rt3[s] = 1'b1; wen3[s] = 1'b1;
  endtask

  task automatic drain();
    @(negedge clk);
    clear_slots(); fifo_count = '0; stall_in = 1'b0; flush = 1'b0;
    div_done = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (slot_ena !== 2'b00 || issue_cnt !== 2'd0) begin
      errors++;
      $display("FAIL reset_idle: slot_ena=%b issue_cnt=%0d expected 00/0", slot_ena, issue_cnt);
    end
    fifo_count = 5'd2;
    set_alu(0, 5'd1, 5'd2, 5'd3);
    set_alu(1, 5'd4, 5'd5, 5'd6);
    #1;
    checks++;
    if (slot_ena !== 2'b11) begin
      errors++;
      $display("FAIL reset_follow: slot_ena=%b expected 11", slot_ena);
    end
    @(negedge clk);
    clear_slots(); fifo_count = '0;
    resetn = 1'b1;
  endtask

  task automatic test_dual_alu();
    @(negedge clk);
    clear_slots(); fifo_count = 5'd2;
    set_alu(0, 5'd2, 5'd3, 5'd1);
    set_alu(1, 5'd5, 5'd6, 5'd4);
    #1;
    checks++;
    if (slot_ena !== 2'b11 || issue_cnt !== 2'd2 || in_ds !== 2'b00) begin
      errors++;
      $display("FAIL dual_alu: ena=%b cnt=%0d ds=%b expected 11/2/00", slot_ena, issue_cnt, in_ds);
    end
    @(negedge clk);
    fifo_count = 5'd1;
    #1;
    checks++;
    if (slot_ena !== 2'b01 || issue_cnt !== 2'd1) begin
      errors++;
      $display("FAIL fifo_one: ena=%b cnt=%0d expected 01/1", slot_ena, issue_cnt);
    end
    @(negedge clk);
    fifo_count = 5'd0;
    #1;
    checks++;
    if (slot_ena !== 2'b00) begin
      errors++;
      $display("FAIL fifo_empty: ena=%b expected 00", slot_ena);
    end
  endtask

  task automatic test_group_rules();
    logic [1:0] exp;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      clear_slots(); fifo_count = 5'd2;
      set_alu(0, 5'd1, 5'd2, 5'd11);
      set_alu(1, 5'd3, 5'd4, 5'd12);
      exp = 2'b01;
      case (k)
        0:  begin is_load = 2'b11; is_mem = 2'b11; waddr = {5'd21, 5'd20}; end
        1:  begin is_mul = 2'b11; waddr = {5'd23, 5'd22}; end
        2:  rs[9:5] = 5'd11;                               // RAW on r11
        3:  begin waddr[4:0] = 5'd0; rs[9:5] = 5'd0; exp = 2'b11; end
        4:  only_one[0] = 1'b1;
        5:  only_one[1] = 1'b1;
        6:  may_flush[1] = 1'b1;
        7:  begin may_flush[0] = 1'b1; exp = 2'b11; end
        8:  begin hilo_w[0] = 1'b1; hilo_r[1] = 1'b1; end
        9:  begin cp0_w[0] = 1'b1; cp0_r[1] = 1'b1; end
        10: begin is_load[0] = 1'b1; is_mem[0] = 1'b1; waddr[4:0] = 5'd24;
                  is_mul[1] = 1'b1; waddr[9:5] = 5'd25; exp = 2'b11; end
        default: begin is_mem[0] = 1'b1; wen[0] = 1'b0;
                  is_load[1] = 1'b1; is_mem[1] = 1'b1; waddr[9:5] = 5'd26; end
      endcase
      #1;
      checks++;
      if (slot_ena !== exp || issue_cnt !== ((exp == 2'b11) ? 2'd2 : 2'd1)) begin
        errors++;
        $display("FAIL group_rule_%0d: ena=%b cnt=%0d expected ena=%b", k, slot_ena, issue_cnt, exp);
      end
    end
  endtask

  task automatic test_load_use();
    logic [1:0] exp_b [5];
    drain();
    // No stall: issue t, held t+1/t+2, issues t+3.
    @(negedge clk);
    clear_slots(); fifo_count = 5'd2;
    set_alu(0, 5'd1, 5'd0, 5'd5); read_rt[0] = 1'b0;
    is_load[0] = 1'b1; is_mem[0] = 1'b1;
    set_alu(1, 5'd5, 5'd2, 5'd7);
    #1;
    checks++;
    if (slot_ena !== 2'b01) begin
      errors++;
      $display("FAIL load_use_t: ena=%b expected 01", slot_ena);
    end
    exp_b[0] = 2'b00; exp_b[1] = 2'b00; exp_b[2] = 2'b01;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      clear_slots(); fifo_count = 5'd1;
      set_alu(0, 5'd5, 5'd2, 5'd7);
      #1;
      checks++;
      if (slot_ena !== exp_b[c]) begin
        errors++;
        $display("FAIL load_use_t+%0d: ena=%b expected %b", c + 1, slot_ena, exp_b[c]);
      end
    end
    // Stall at t+1 pushes the dependant to t+4.
    drain();
    @(negedge clk);
    clear_slots(); fifo_count = 5'd1;
    set_alu(0, 5'd1, 5'd0, 5'd5); read_rt[0] = 1'b0;
    is_load[0] = 1'b1; is_mem[0] = 1'b1;
    #1;
    checks++;
    if (slot_ena !== 2'b01) begin
      errors++;
      $display("FAIL load_stall_t: ena=%b expected 01", slot_ena);
    end
    exp_b[0] = 2'b00; exp_b[1] = 2'b00; exp_b[2] = 2'b00; exp_b[3] = 2'b01;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      clear_slots(); fifo_count = 5'd1;
      set_alu(0, 5'd5, 5'd2, 5'd7);
      stall_in = (c == 0);
      #1;
      checks++;
      if (slot_ena !== exp_b[c]) begin
        errors++;
        $display("FAIL load_stall_t+%0d: ena=%b expected %b", c + 1, slot_ena, exp_b[c]);
      end
    end
    stall_in = 1'b0;
  endtask

  task automatic test_flush_stall();
    drain();
    @(negedge clk);
    clear_slots(); fifo_count = 5'd2;
    set_alu(0, 5'd1, 5'd2, 5'd3); set_alu(1, 5'd4, 5'd5, 5'd6);
    stall_in = 1'b1;
    #1;
    checks++;
    if (slot_ena !== 2'b00 || issue_cnt !== 2'd0) begin
      errors++;
      $display("FAIL stall_block: ena=%b cnt=%0d expected 00/0", slot_ena, issue_cnt);
    end
    stall_in = 1'b0;
    // Load r5, then flush for one cycle: the counter must keep running.
    @(negedge clk);
    clear_slots(); fifo_count = 5'd1;
    set_alu(0, 5'd1, 5'd0, 5'd5); read_rt[0] = 1'b0;
    is_load[0] = 1'b1; is_mem[0] = 1'b1;
    #1;
    checks++;
    if (slot_ena !== 2'b01) begin
      errors++;
      $display("FAIL flush_load: ena=%b expected 01", slot_ena);
    end
    @(negedge clk);
    clear_slots(); fifo_count = 5'd2;
    set_alu(0, 5'd1, 5'd2, 5'd3); set_alu(1, 5'd4, 5'd6, 5'd8);
    flush = 1'b1;
    #1;
    checks++;
    if (slot_ena !== 2'b00) begin
      errors++;
      $display("FAIL flush_block: ena=%b expected 00", slot_ena);
    end
    @(negedge clk);
    flush = 1'b0;
    clear_slots(); fifo_count = 5'd1;
    set_alu(0, 5'd5, 5'd2, 5'd7);
    #1;
    checks++;
    if (slot_ena !== 2'b00) begin
      errors++;
      $display("FAIL flush_count_t+2: ena=%b expected 00", slot_ena);
    end
    @(negedge clk);
    #1;
    checks++;
    if (slot_ena !== 2'b01) begin
      errors++;
      $display("FAIL flush_count_t+3: ena=%b expected 01", slot_ena);
    end
  endtask

  task automatic present_div();
    clear_slots(); fifo_count = 5'd1;
    rs[4:0] = 5'd1; rt[4:0] = 5'd2; read_rs[0] = 1'b1; read_rt[0] = 1'b1;
    is_div[0] = 1'b1;
  endtask

  task automatic present_mfhi();
    clear_slots(); fifo_count = 5'd1;
    hilo_r[0] = 1'b1; wen[0] = 1'b1; waddr[4:0] = 5'd3;
  endtask

  task automatic test_div_hilo();
    logic [1:0] exp_m [4];
    drain();
    @(negedge clk); present_div(); #1;
    checks++;
    if (slot_ena !== 2'b01) begin
      errors++; $display("FAIL div_issue: ena=%b expected 01", slot_ena);
    end
    @(negedge clk); present_mfhi(); #1;
    checks++;
    if (slot_ena !== 2'b00) begin
      errors++; $display("FAIL mfhi_busy: ena=%b expected 00", slot_ena);
    end
    @(negedge clk); div_done = 1'b1; #1;
    checks++;
    if (slot_ena !== 2'b00) begin
      errors++; $display("FAIL mfhi_done_cycle: ena=%b expected 00", slot_ena);
    end
    @(negedge clk); div_done = 1'b0; #1;
    checks++;
    if (slot_ena !== 2'b01) begin
      errors++; $display("FAIL mfhi_after_done: ena=%b expected 01", slot_ena);
    end
    // New div coinciding with div_done: busy must stay set.
    @(negedge clk); present_div(); div_done = 1'b1; #1;
    checks++;
    if (slot_ena !== 2'b01) begin
      errors++; $display("FAIL div_coincide_issue: ena=%b expected 01", slot_ena);
    end
    @(negedge clk); div_done = 1'b0; present_mfhi(); #1;
    checks++;
    if (slot_ena !== 2'b00) begin
      errors++; $display("FAIL div_coincide_busy: ena=%b expected 00", slot_ena);
    end
    @(negedge clk); div_done = 1'b1;
    @(negedge clk); div_done = 1'b0; #1;
    checks++;
    if (slot_ena !== 2'b01) begin
      errors++; $display("FAIL div_coincide_clear: ena=%b expected 01", slot_ena);
    end
    // MULT writing HI/LO: MFHI held t+1..t+3, issues t+4.
    @(negedge clk);
    clear_slots(); fifo_count = 5'd1;
    rs[4:0] = 5'd1; rt[4:0] = 5'd2; read_rs[0] = 1'b1; read_rt[0] = 1'b1;
    is_mul[0] = 1'b1; hilo_w[0] = 1'b1;
    #1;
    checks++;
    if (slot_ena !== 2'b01) begin
      errors++; $display("FAIL mult_issue: ena=%b expected 01", slot_ena);
    end
    exp_m[0] = 2'b00; exp_m[1] = 2'b00; exp_m[2] = 2'b00; exp_m[3] = 2'b01;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk); present_mfhi(); #1;
      checks++;
      if (slot_ena !== exp_m[c]) begin
        errors++;
        $display("FAIL mult_hilo_t+%0d: ena=%b expected %b", c + 1, slot_ena, exp_m[c]);
      end
    end
  endtask

  task automatic test_reset_mid_div();
    drain();
    @(negedge clk); present_div();
    @(negedge clk); present_mfhi(); #1;
    checks++;
    if (slot_ena !== 2'b00) begin
      errors++; $display("FAIL rst_div_busy: ena=%b expected 00", slot_ena);
    end
    resetn = 1'b0;
    #1;
    checks++;
    if (slot_ena !== 2'b01) begin
      errors++; $display("FAIL rst_div_clear: ena=%b expected 01", slot_ena);
    end
    @(negedge clk);
    clear_slots(); fifo_count = '0;
    resetn = 1'b1;
  endtask

  task automatic test_branch();
    @(negedge clk);
    clear3(); fifo3 = 5'd3;
    set_alu3(0, 5'd1, 5'd2, 5'd0); wen3[0] = 1'b0; branch3[0] = 1'b1;
    set_alu3(1, 5'd3, 5'd4, 5'd5);
    set_alu3(2, 5'd6, 5'd7, 5'd8);
    #1;
    checks++;
    if (ena3 !== 3'b011 || ds3 !== 3'b010 || cnt3 !== 2'd2) begin
      errors++;
      $display("FAIL branch_slot0: ena=%b ds=%b cnt=%0d expected 011/010/2", ena3, ds3, cnt3);
    end
    @(negedge clk);
    branch3 = 3'b010; wen3[0] = 1'b1; waddr3[4:0] = 5'd9;
    #1;
    checks++;
    if (ena3 !== 3'b111 || ds3 !== 3'b100 || cnt3 !== 2'd3) begin
      errors++;
      $display("FAIL branch_slot1: ena=%b ds=%b cnt=%0d expected 111/100/3", ena3, ds3, cnt3);
    end
    @(negedge clk);
    branch3 = 3'b000; fifo3 = 5'd2;
    #1;
    checks++;
    if (ena3 !== 3'b011 || ds3 !== 3'b000) begin
      errors++;
      $display("FAIL w3_fifo_two: ena=%b ds=%b expected 011/000", ena3, ds3);
    end
    @(negedge clk);
    clear3();
  endtask

`ifdef ISSUE_PERF_CNT_EN
  task automatic test_perf();
    drain();
    resetn = 1'b0; #1; resetn = 1'b1;
    @(negedge clk); present_div();
    repeat (10) begin
      @(negedge clk); present_mfhi();
    end
    @(negedge clk); clear_slots(); fifo_count = '0; #1;
    checks++;
    if (perf_stall !== 32'd10 || perf_full !== 32'd0) begin
      errors++;
      $display("FAIL perf_stall: stall=%0d full=%0d expected 10/0", perf_stall, perf_full);
    end
  endtask
`endif

  initial begin
    resetn = 1'b0; stall_in = 1'b0; flush = 1'b0; div_done = 1'b0;
    fifo_count = '0; zero3 = '0;
    clear_slots(); clear3();
    test_reset();
    test_dual_alu();
    test_group_rules();
    test_load_use();
    test_flush_stall();
    test_div_hilo();
    test_reset_mid_div();
    test_branch();
`ifdef ISSUE_PERF_CNT_EN
    test_perf();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
